// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel counter/timer: register map,
// mode encodings, STATUS/CTRL bit positions and a byte-merge helper.
package timer_pkg;

  typedef enum logic [1:0] {
    MODE_STOP    = 2'b00,
    MODE_CTC     = 2'b01,
    MODE_PWM     = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_CMP_IE   = 8'h01;
  localparam logic [7:0] ADDR_PS_LO    = 8'h02;
  localparam logic [7:0] ADDR_PS_HI    = 8'h03;
  localparam logic [7:0] ADDR_STATUS   = 8'h04;
  localparam logic [7:0] ADDR_TOP_LO   = 8'h06;
  localparam logic [7:0] ADDR_TOP_HI   = 8'h07;
  localparam logic [7:0] ADDR_CNT_LO   = 8'h08;
  localparam logic [7:0] ADDR_CNT_HI   = 8'h09;
  localparam logic [7:0] ADDR_CAP_LO   = 8'h0A;
  localparam logic [7:0] ADDR_CAP_HI   = 8'h0B;
  localparam logic [7:0] ADDR_CMP_BASE = 8'h10;

  localparam int ST_TOP  = 0;
  localparam int ST_CAP  = 1;
  localparam int ST_CMP0 = 2;
  localparam int ST_OVR  = 7;

  localparam int CTRL_CAP_EN   = 2;
  localparam int CTRL_CAP_FALL = 3;
  localparam int CTRL_TOP_IE   = 4;
  localparam int CTRL_CAP_IE   = 5;

  // Registers narrower than 16 bits are widened, merged, then truncated,
  // which makes writes to non-existent upper bits vanish naturally.
  function automatic logic [15:0] merge_byte(input logic [15:0] cur,
                                             input logic [7:0]  data,
                                             input logic        wr_lo,
                                             input logic        wr_hi);
    logic [15:0] res;
    res = cur;
    if (wr_lo) res[7:0] = data;
    if (wr_hi) res[15:8] = data;
    return res;
  endfunction

endpackage

// File: rtl/multi_timer_if.sv
// 8-bit I/O bus shared by the peripheral blocks: address, write data,
// one-cycle strobes and registered read data.
interface multi_timer_if;
  logic [7:0] address;
  logic [7:0] din;
  logic [7:0] dout;
  logic       w_en;
  logic       r_en;

  modport master (output address, output din, output w_en, output r_en, input dout);
  modport slave  (input address, input din, input w_en, input r_en, output dout);
endinterface

// File: rtl/timer_prescaler.sv
// Free-running prescaler: emits a one-cycle tick when the count matches
// the programmed divisor, held at zero while the timer is stopped.
module timer_prescaler #(
  parameter int PS_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PS_WIDTH-1:0] prescale,
  output logic                tick
);

  logic [PS_WIDTH-1:0] ps_cnt_reg;

  assign tick = enable && (ps_cnt_reg == prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt_reg <= '0;
    end else if (!enable || tick) begin
      ps_cnt_reg <= '0;
    end else begin
      ps_cnt_reg <= ps_cnt_reg + PS_WIDTH'(1);
    end
  end

endmodule

// File: rtl/multi_timer.sv
// Memory-mapped counter/timer with prescaler, NUM_CMP compare channels
// (CTC toggle, buffered PWM, one-shot) and synchronised input capture.
module multi_timer
  import timer_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int NUM_CMP   = 2,
  parameter int PS_WIDTH  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  multi_timer_if.slave       bus,
  input  logic               cap_in,
  output logic [NUM_CMP-1:0] cmp_out,
  output logic               irq_top,
  output logic               irq_cap,
  output logic [NUM_CMP-1:0] irq_cmp
);

  mode_e                 mode_reg, mode_next;
  logic [5:2]            ctrl_reg;
  logic [NUM_CMP-1:0]    cmp_ie_reg;
  logic [PS_WIDTH-1:0]   prescale_reg;
  logic [CNT_WIDTH-1:0]  top_reg, count_reg, count_next, capture_reg;
  logic [7:0]            cnt_snap_reg, cap_snap_reg, dout_reg, rd_data, status_byte;
  logic                  top_flag_reg, cap_flag_reg, ovr_flag_reg;
  logic                  cap_meta_reg, cap_sync_reg, cap_prev_reg, cap_edge, cap_event;
  logic                  tick, run, tick_eff, top_hit, wrap, oneshot_end;
  logic                  st_wr, cnt_wr_lo, cnt_wr_hi;
  logic [15:0]           count16, capture16, top16, ps16, top_wide, ps_wide, cnt_wide;

  logic [NUM_CMP-1:0][CNT_WIDTH-1:0] cmp_buf_q;
  logic [NUM_CMP-1:0]                cmp_out_q, cmp_flag_q;

  assign run         = (mode_reg != MODE_STOP);
  assign st_wr       = bus.w_en && (bus.address == ADDR_STATUS);
  assign cnt_wr_lo   = bus.w_en && (bus.address == ADDR_CNT_LO);
  assign cnt_wr_hi   = bus.w_en && (bus.address == ADDR_CNT_HI);
  // A software load of COUNT takes precedence over the tick of that cycle.
  assign tick_eff    = tick && !(cnt_wr_lo || cnt_wr_hi);
  assign top_hit     = tick_eff && (count_reg == top_reg);
  assign wrap        = top_hit && (mode_reg == MODE_PWM || mode_reg == MODE_ONESHOT);
  assign oneshot_end = top_hit && (mode_reg == MODE_ONESHOT);

  assign count16   = 16'(count_reg);
  assign capture16 = 16'(capture_reg);
  assign top16     = 16'(top_reg);
  assign ps16      = 16'(prescale_reg);
  assign top_wide  = merge_byte(top16, bus.din, bus.w_en && bus.address == ADDR_TOP_LO,
                                bus.w_en && bus.address == ADDR_TOP_HI);
  assign ps_wide   = merge_byte(ps16, bus.din, bus.w_en && bus.address == ADDR_PS_LO,
                                bus.w_en && bus.address == ADDR_PS_HI);
  assign cnt_wide  = merge_byte(count16, bus.din, cnt_wr_lo, cnt_wr_hi);

  timer_prescaler #(.PS_WIDTH(PS_WIDTH)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (run),
    .prescale (prescale_reg),
    .tick     (tick)
  );

  // Mode state: software writes win over the one-shot self-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_reg <= MODE_STOP;
    else        mode_reg <= mode_next;
  end

  always_comb begin
    mode_next = mode_reg;
    if (bus.w_en && bus.address == ADDR_CTRL) mode_next = mode_e'(bus.din[1:0]);
    else if (oneshot_end)                     mode_next = MODE_STOP;
  end

  always_comb begin
    count_next = count_reg;
    if (!run)                        count_next = '0;
    else if (cnt_wr_lo || cnt_wr_hi) count_next = cnt_wide[CNT_WIDTH-1:0];
    else if (top_hit)                count_next = '0;
    else if (tick_eff)               count_next = count_reg + CNT_WIDTH'(1);
  end

  assign cap_edge  = ctrl_reg[CTRL_CAP_FALL] ? (cap_prev_reg & ~cap_sync_reg)
                                             : (cap_sync_reg & ~cap_prev_reg);
  assign cap_event = run && ctrl_reg[CTRL_CAP_EN] && cap_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg     <= '0;
      cmp_ie_reg   <= '0;
      prescale_reg <= '0;
      top_reg      <= '1;
      count_reg    <= '0;
      capture_reg  <= '0;
      cnt_snap_reg <= 8'h00;
      cap_snap_reg <= 8'h00;
      dout_reg     <= 8'h00;
      top_flag_reg <= 1'b0;
      cap_flag_reg <= 1'b0;
      ovr_flag_reg <= 1'b0;
      cap_meta_reg <= 1'b0;
      cap_sync_reg <= 1'b0;
      cap_prev_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      top_reg      <= top_wide[CNT_WIDTH-1:0];
      prescale_reg <= ps_wide[PS_WIDTH-1:0];
      if (bus.w_en && bus.address == ADDR_CTRL)   ctrl_reg   <= bus.din[5:2];
      if (bus.w_en && bus.address == ADDR_CMP_IE) cmp_ie_reg <= bus.din[NUM_CMP-1:0];

      cap_meta_reg <= cap_in;
      cap_sync_reg <= cap_meta_reg;
      cap_prev_reg <= cap_sync_reg;
      if (cap_event) capture_reg <= count_reg;

      // Sticky flags: a set in the same cycle as a write-1 clear wins.
      top_flag_reg <= (top_flag_reg & ~(st_wr & bus.din[ST_TOP])) | top_hit;
      cap_flag_reg <= (cap_flag_reg & ~(st_wr & bus.din[ST_CAP])) | cap_event;
      ovr_flag_reg <= (ovr_flag_reg & ~(st_wr & bus.din[ST_OVR])) | (cap_event & cap_flag_reg);

      if (bus.r_en) begin
        dout_reg <= rd_data;
        if (bus.address == ADDR_CNT_LO) cnt_snap_reg <= count16[15:8];
        if (bus.address == ADDR_CAP_LO) cap_snap_reg <= capture16[15:8];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CMP; gi++) begin : g_cmp
    logic [CNT_WIDTH-1:0] buf_reg, act_reg, act_eff;
    logic [15:0]          buf_wide;
    logic                 out_reg, flag_reg, hit;

    assign buf_wide = merge_byte(16'(buf_reg), bus.din,
                                 bus.w_en && bus.address == ADDR_CMP_BASE + 8'(2 * gi),
                                 bus.w_en && bus.address == ADDR_CMP_BASE + 8'(2 * gi + 1));
    // On the wrap tick the freshly loaded compare value already governs count 0.
    assign act_eff  = wrap ? buf_reg : act_reg;
    assign hit      = tick_eff && (count_reg == act_reg);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        buf_reg  <= '0;
        act_reg  <= '0;
        out_reg  <= 1'b0;
        flag_reg <= 1'b0;
      end else begin
        buf_reg <= buf_wide[CNT_WIDTH-1:0];
        if (!run || mode_reg == MODE_CTC || wrap) act_reg <= buf_reg;
        if (!run) begin
          out_reg <= 1'b0;
        end else if (tick_eff) begin
          case (mode_reg)
            MODE_CTC:     if (hit) out_reg <= ~out_reg;
            MODE_PWM:     out_reg <= (count_next < act_eff);
            MODE_ONESHOT: out_reg <= !oneshot_end && (count_next < act_eff);
            default:      out_reg <= 1'b0;
          endcase
        end
        flag_reg <= (flag_reg & ~(st_wr & bus.din[ST_CMP0 + gi])) | hit;
      end
    end

    assign cmp_buf_q[gi]  = buf_reg;
    assign cmp_out_q[gi]  = out_reg;
    assign cmp_flag_q[gi] = flag_reg;
  end

  assign status_byte = {ovr_flag_reg, 1'b0, 4'(cmp_flag_q), cap_flag_reg, top_flag_reg};

  always_comb begin
    logic [15:0] cmp16;
    cmp16   = 16'h0000;
    rd_data = 8'h00;
    case (bus.address)
      ADDR_CTRL:   rd_data = {2'b00, ctrl_reg, mode_reg};
      ADDR_CMP_IE: rd_data = 8'(cmp_ie_reg);
      ADDR_PS_LO:  rd_data = ps16[7:0];
      ADDR_PS_HI:  rd_data = ps16[15:8];
      ADDR_STATUS: rd_data = status_byte;
      ADDR_TOP_LO: rd_data = top16[7:0];
      ADDR_TOP_HI: rd_data = top16[15:8];
      ADDR_CNT_LO: rd_data = count16[7:0];
      ADDR_CNT_HI: rd_data = cnt_snap_reg;
      ADDR_CAP_LO: rd_data = capture16[7:0];
      ADDR_CAP_HI: rd_data = cap_snap_reg;
      default:     rd_data = 8'h00;
    endcase
    for (int k = 0; k < NUM_CMP; k++) begin
      cmp16 = 16'(cmp_buf_q[k]);
      if (bus.address == ADDR_CMP_BASE + 8'(2 * k))     rd_data = cmp16[7:0];
      if (bus.address == ADDR_CMP_BASE + 8'(2 * k + 1)) rd_data = cmp16[15:8];
    end
  end

  assign bus.dout = dout_reg;
  assign cmp_out  = cmp_out_q;
  assign irq_top  = top_flag_reg & ctrl_reg[CTRL_TOP_IE];
  assign irq_cap  = cap_flag_reg & ctrl_reg[CTRL_CAP_IE];
  assign irq_cmp  = cmp_flag_q & cmp_ie_reg;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: register map, CTC, PWM, buffered compare,
// one-shot, capture/overrun, flag clear race and asynchronous reset.
module tb_multi_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cap_in;
  logic [1:0] cmp_out;
  logic [1:0] irq_cmp;
  logic       irq_top;
  logic       irq_cap;
  int         n_cmp = 0;
  int         n_bad = 0;

  multi_timer_if bus_if();

  multi_timer #(.CNT_WIDTH(16), .NUM_CMP(2), .PS_WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if),
    .cap_in  (cap_in),
    .cmp_out (cmp_out),
    .irq_top (irq_top),
    .irq_cap (irq_cap),
    .irq_cmp (irq_cmp)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_if.address = a;
    bus_if.din     = d;
    bus_if.w_en    = 1'b1;
    @(posedge clk); #1;
    bus_if.w_en    = 1'b0;
    $display("[%0t] WR addr=%02h data=%02h", $time, a, d);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    bus_if.address = a;
    bus_if.r_en    = 1'b1;
    @(posedge clk); #1;
    bus_if.r_en    = 1'b0;
    d = bus_if.dout;
    $display("[%0t] RD addr=%02h data=%02h", $time, a, d);
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({bus_if.dout, cmp_out, irq_top, irq_cap, irq_cmp} !== 14'h0) begin
      n_bad++; $display("FAIL reset_outputs got=%h exp=0", {bus_if.dout, cmp_out, irq_top, irq_cap, irq_cmp});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_read(8'h07, rd);
    n_cmp++; if (rd !== 8'hFF) begin n_bad++; $display("FAIL reset_top_hi got=%02h exp=ff", rd); end
    bus_read(8'h06, rd);
    n_cmp++; if (rd !== 8'hFF) begin n_bad++; $display("FAIL reset_top_lo got=%02h exp=ff", rd); end
    bus_read(8'h00, rd);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL reset_ctrl got=%02h exp=00", rd); end
  endtask

  task automatic test_registers();
    logic [7:0] rd;
    bus_write(8'h01, 8'hFF);
    bus_read(8'h01, rd);
    n_cmp++; if (rd !== 8'h03) begin n_bad++; $display("FAIL cmp_ie_width got=%02h exp=03", rd); end
    bus_write(8'h01, 8'h00);
    bus_write(8'h14, 8'h55);
    bus_read(8'h14, rd);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL unmapped_cmp2 got=%02h exp=00", rd); end
    bus_read(8'h05, rd);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL unmapped_05 got=%02h exp=00", rd); end
  endtask

  task automatic test_ctc();
    bus_write(8'h06, 8'h09);
    bus_write(8'h07, 8'h00);
    bus_write(8'h10, 8'h09);
    bus_write(8'h11, 8'h00);
    bus_write(8'h04, 8'hFF);
    bus_write(8'h00, 8'h11);
    repeat (9) @(posedge clk);
    #1;
    n_cmp++; if (irq_top !== 1'b0) begin n_bad++; $display("FAIL ctc_top_early got=%b exp=0", irq_top); end
    n_cmp++; if (cmp_out[0] !== 1'b0) begin n_bad++; $display("FAIL ctc_out_early got=%b exp=0", cmp_out[0]); end
    @(posedge clk); #1;
    n_cmp++; if (irq_top !== 1'b1) begin n_bad++; $display("FAIL ctc_top_10 got=%b exp=1", irq_top); end
    n_cmp++; if (cmp_out[0] !== 1'b1) begin n_bad++; $display("FAIL ctc_toggle_10 got=%b exp=1", cmp_out[0]); end
    repeat (9) @(posedge clk);
    #1;
    n_cmp++; if (cmp_out[0] !== 1'b1) begin n_bad++; $display("FAIL ctc_hold_19 got=%b exp=1", cmp_out[0]); end
    @(posedge clk); #1;
    n_cmp++; if (cmp_out[0] !== 1'b0) begin n_bad++; $display("FAIL ctc_toggle_20 got=%b exp=0", cmp_out[0]); end
  endtask

  task automatic test_status_race();
    bus_write(8'h00, 8'h00);
    bus_write(8'h04, 8'hFF);
    bus_write(8'h00, 8'h11);
    repeat (9) @(posedge clk);
    #1;
    bus_write(8'h04, 8'h01);
    n_cmp++; if (irq_top !== 1'b1) begin n_bad++; $display("FAIL clear_race_set_wins got=%b exp=1", irq_top); end
    bus_write(8'h04, 8'h01);
    n_cmp++; if (irq_top !== 1'b0) begin n_bad++; $display("FAIL clear_top got=%b exp=0", irq_top); end
  endtask

  task automatic test_pwm();
    int ones0;
    int ones1;
    bus_write(8'h00, 8'h00);
    bus_write(8'h06, 8'h03);
    bus_write(8'h07, 8'h00);
    bus_write(8'h10, 8'h01);
    bus_write(8'h12, 8'h04);
    bus_write(8'h13, 8'h00);
    bus_write(8'h01, 8'h03);
    bus_write(8'h04, 8'hFF);
    bus_write(8'h00, 8'h02);
    repeat (8) @(posedge clk);
    ones0 = 0; ones1 = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      ones0 += int'(cmp_out[0]);
      ones1 += int'(cmp_out[1]);
    end
    n_cmp++; if (ones0 != 10) begin n_bad++; $display("FAIL pwm_duty_1of4 got=%0d exp=10", ones0); end
    n_cmp++; if (ones1 != 40) begin n_bad++; $display("FAIL pwm_duty_100 got=%0d exp=40", ones1); end
    n_cmp++; if (irq_cmp !== 2'b01) begin n_bad++; $display("FAIL pwm_irq_cmp got=%b exp=01", irq_cmp); end
    bus_write(8'h10, 8'h00);
    repeat (8) @(posedge clk);
    ones0 = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      ones0 += int'(cmp_out[0]);
    end
    n_cmp++; if (ones0 != 0) begin n_bad++; $display("FAIL pwm_duty_0 got=%0d exp=0", ones0); end
  endtask

  task automatic test_pwm_buffered();
    logic       prev;
    logic       found;
    logic [3:0] grp;
    logic [39:0] smp;
    int         bad;
    bus_write(8'h10, 8'h01);
    repeat (8) @(posedge clk);
    #1;
    prev = cmp_out[0]; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (!prev && cmp_out[0]) found = 1'b1;
      prev = cmp_out[0];
    end
    @(posedge clk); #1;
    bus_write(8'h10, 8'h03);
    prev = cmp_out[0]; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (!prev && cmp_out[0]) found = 1'b1;
      prev = cmp_out[0];
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL pwm_rise_timeout got=none exp=rise"); end
    smp[0] = cmp_out[0];
    for (int i = 1; i < 40; i++) begin
      @(posedge clk); #1;
      smp[i] = cmp_out[0];
    end
    bad = 0;
    for (int g = 0; g < 10; g++) begin
      grp = {smp[4*g], smp[4*g+1], smp[4*g+2], smp[4*g+3]};
      if (grp != 4'b1000 && grp != 4'b1110) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL pwm_runt_periods got=%0d exp=0", bad); end
    n_cmp++; if (grp !== 4'b1110) begin n_bad++; $display("FAIL pwm_new_duty got=%b exp=1110", grp); end
  endtask

  task automatic test_oneshot();
    logic [7:0] rd;
    bus_write(8'h00, 8'h00);
    bus_write(8'h04, 8'hFF);
    bus_write(8'h06, 8'h05);
    bus_write(8'h02, 8'h01);
    bus_write(8'h00, 8'h13);
    repeat (6) @(posedge clk);
    #1;
    bus_read(8'h08, rd);
    n_cmp++; if (rd !== 8'h03) begin n_bad++; $display("FAIL oneshot_mid_count got=%02h exp=03", rd); end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (irq_top !== 1'b0) begin n_bad++; $display("FAIL oneshot_top_early got=%b exp=0", irq_top); end
    @(posedge clk); #1;
    n_cmp++; if (irq_top !== 1'b1) begin n_bad++; $display("FAIL oneshot_top_12 got=%b exp=1", irq_top); end
    bus_read(8'h00, rd);
    n_cmp++; if (rd !== 8'h10) begin n_bad++; $display("FAIL oneshot_mode_clear got=%02h exp=10", rd); end
    bus_read(8'h08, rd);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL oneshot_count_end got=%02h exp=00", rd); end
    n_cmp++; if (cmp_out !== 2'b00) begin n_bad++; $display("FAIL oneshot_outputs got=%b exp=00", cmp_out); end
  endtask

  task automatic pulse_cap();
    cap_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    cap_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_capture();
    logic [7:0] rd;
    bus_write(8'h00, 8'h00);
    bus_write(8'h04, 8'hFF);
    bus_write(8'h02, 8'hFF);
    bus_write(8'h03, 8'hFF);
    bus_write(8'h06, 8'hFF);
    bus_write(8'h07, 8'hFF);
    bus_write(8'h00, 8'h05);
    bus_write(8'h09, 8'h12);
    bus_write(8'h08, 8'h34);
    pulse_cap();
    bus_read(8'h0A, rd);
    n_cmp++; if (rd !== 8'h34) begin n_bad++; $display("FAIL cap1_lo got=%02h exp=34", rd); end
    bus_read(8'h0B, rd);
    n_cmp++; if (rd !== 8'h12) begin n_bad++; $display("FAIL cap1_hi got=%02h exp=12", rd); end
    bus_read(8'h04, rd);
    n_cmp++; if (rd !== 8'h02) begin n_bad++; $display("FAIL cap1_status got=%02h exp=02", rd); end
    bus_write(8'h08, 8'h40);
    pulse_cap();
    bus_read(8'h0A, rd);
    n_cmp++; if (rd !== 8'h40) begin n_bad++; $display("FAIL cap2_lo got=%02h exp=40", rd); end
    bus_read(8'h0B, rd);
    n_cmp++; if (rd !== 8'h12) begin n_bad++; $display("FAIL cap2_hi got=%02h exp=12", rd); end
    bus_read(8'h04, rd);
    n_cmp++; if (rd !== 8'h82) begin n_bad++; $display("FAIL cap2_overrun got=%02h exp=82", rd); end
    bus_write(8'h00, 8'h25);
    n_cmp++; if (irq_cap !== 1'b1) begin n_bad++; $display("FAIL cap_irq got=%b exp=1", irq_cap); end
  endtask

  task automatic test_reset_mid_pwm();
    logic [7:0] rd;
    bus_write(8'h00, 8'h00);
    bus_write(8'h04, 8'hFF);
    bus_write(8'h02, 8'h00);
    bus_write(8'h03, 8'h00);
    bus_write(8'h06, 8'h03);
    bus_write(8'h07, 8'h00);
    bus_write(8'h00, 8'h12);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if ({irq_top, cmp_out[1]} !== 2'b11) begin
      n_bad++; $display("FAIL pre_reset_active got=%b exp=11", {irq_top, cmp_out[1]});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({cmp_out, irq_top, irq_cap, irq_cmp} !== 6'b0) begin
      n_bad++; $display("FAIL async_reset_outputs got=%b exp=000000", {cmp_out, irq_top, irq_cap, irq_cmp});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_read(8'h07, rd);
    n_cmp++; if (rd !== 8'hFF) begin n_bad++; $display("FAIL post_reset_top got=%02h exp=ff", rd); end
    bus_read(8'h00, rd);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL post_reset_ctrl got=%02h exp=00", rd); end
  endtask

  initial begin
    bus_if.address = 8'h00;
    bus_if.din     = 8'h00;
    bus_if.w_en    = 1'b0;
    bus_if.r_en    = 1'b0;
    cap_in         = 1'b0;
    rst_n          = 1'b0;
    test_reset();
    test_registers();
    test_ctc();
    test_status_race();
    test_pwm();
    test_pwm_buffered();
    test_oneshot();
    test_capture();
    test_reset_mid_pwm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
